// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX-side operand forwarding and load-use hazard detection.
// Produces the ALU a/b/shamt/control inputs and the forwarded store data every cycle.
module id_ex_operand_stage #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int SHAMT_W = 6
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               id_valid_i,
  input  logic [DATA_W-1:0]  id_rs_data_i,
  input  logic [DATA_W-1:0]  id_rt_data_i,
  input  logic [15:0]        id_imm_i,
  input  logic               id_imm_zext_i,
  input  logic [REG_AW-1:0]  id_rs_i,
  input  logic [REG_AW-1:0]  id_rt_i,
  input  logic               id_uses_rt_i,
  input  logic [REG_AW-1:0]  id_dest_i,
  input  logic               id_alusrc_i,
  input  logic [2:0]         id_alu_control_i,
  input  logic [SHAMT_W-1:0] id_shamt_i,
  input  logic               id_regwrite_i,
  input  logic               id_memread_i,
  input  logic               id_memwrite_i,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic               exmem_regwrite_i,
  input  logic [REG_AW-1:0]  exmem_dest_i,
  input  logic [DATA_W-1:0]  exmem_result_i,
  input  logic               memwb_regwrite_i,
  input  logic [REG_AW-1:0]  memwb_dest_i,
  input  logic [DATA_W-1:0]  memwb_result_i,
  output logic [DATA_W-1:0]  alu_a_o,
  output logic [DATA_W-1:0]  alu_b_o,
  output logic [SHAMT_W-1:0] alu_shamt_o,
  output logic [2:0]         alu_control_o,
  output logic [DATA_W-1:0]  ex_store_data_o,
  output logic               ex_valid_o,
  output logic [REG_AW-1:0]  ex_dest_o,
  output logic               ex_regwrite_o,
  output logic               ex_memread_o,
  output logic               ex_memwrite_o,
  output logic               load_use_stall_o
);

  localparam logic [2:0] BUBBLE_ALU_CTL = 3'b010;

  logic               ex_valid_q,     ex_valid_d;
  logic [DATA_W-1:0]  ex_rs_data_q,   ex_rs_data_d;
  logic [DATA_W-1:0]  ex_rt_data_q,   ex_rt_data_d;
  logic [DATA_W-1:0]  ex_imm_q,       ex_imm_d;
  logic [REG_AW-1:0]  ex_rs_q,        ex_rs_d;
  logic [REG_AW-1:0]  ex_rt_q,        ex_rt_d;
  logic [REG_AW-1:0]  ex_dest_q,      ex_dest_d;
  logic               ex_alusrc_q,    ex_alusrc_d;
  logic [2:0]         ex_alu_ctl_q,   ex_alu_ctl_d;
  logic [SHAMT_W-1:0] ex_shamt_q,     ex_shamt_d;
  logic               ex_regwrite_q,  ex_regwrite_d;
  logic               ex_memread_q,   ex_memread_d;
  logic               ex_memwrite_q,  ex_memwrite_d;

  logic [DATA_W-1:0]  imm_ext;
  logic               load_use;
  logic               do_bubble;
  logic               do_load;
  logic [DATA_W-1:0]  fwd_rs;
  logic [DATA_W-1:0]  fwd_rt;

  assign imm_ext = id_imm_zext_i ? {{(DATA_W-16){1'b0}}, id_imm_i}
                                 : {{(DATA_W-16){id_imm_i[15]}}, id_imm_i};

  assign load_use = ex_valid_q & ex_memread_q & ex_regwrite_q & (ex_dest_q != '0) &
                    id_valid_i &
                    ((id_rs_i == ex_dest_q) | (id_uses_rt_i & (id_rt_i == ex_dest_q)));

  // flush outranks stall, which outranks the load-use bubble
  assign do_bubble = flush_i | (~stall_i & load_use);
  assign do_load   = ~flush_i & ~stall_i & ~load_use;

  always_comb begin
    ex_valid_d    = ex_valid_q;
    ex_rs_data_d  = ex_rs_data_q;
    ex_rt_data_d  = ex_rt_data_q;
    ex_imm_d      = ex_imm_q;
    ex_rs_d       = ex_rs_q;
    ex_rt_d       = ex_rt_q;
    ex_dest_d     = ex_dest_q;
    ex_alusrc_d   = ex_alusrc_q;
    ex_alu_ctl_d  = ex_alu_ctl_q;
    ex_shamt_d    = ex_shamt_q;
    ex_regwrite_d = ex_regwrite_q;
    ex_memread_d  = ex_memread_q;
    ex_memwrite_d = ex_memwrite_q;
    if (do_bubble) begin
      ex_valid_d    = 1'b0;
      ex_rs_data_d  = '0;
      ex_rt_data_d  = '0;
      ex_imm_d      = '0;
      ex_rs_d       = '0;
      ex_rt_d       = '0;
      ex_dest_d     = '0;
      ex_alusrc_d   = 1'b0;
      ex_alu_ctl_d  = BUBBLE_ALU_CTL;
      ex_shamt_d    = '0;
      ex_regwrite_d = 1'b0;
      ex_memread_d  = 1'b0;
      ex_memwrite_d = 1'b0;
    end else if (do_load) begin
      ex_valid_d    = id_valid_i;
      ex_rs_data_d  = id_rs_data_i;
      ex_rt_data_d  = id_rt_data_i;
      ex_imm_d      = imm_ext;
      ex_rs_d       = id_rs_i;
      ex_rt_d       = id_rt_i;
      ex_dest_d     = id_dest_i;
      ex_alusrc_d   = id_alusrc_i;
      ex_alu_ctl_d  = id_alu_control_i;
      ex_shamt_d    = id_shamt_i;
      ex_regwrite_d = id_regwrite_i;
      ex_memread_d  = id_memread_i;
      ex_memwrite_d = id_memwrite_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ex_valid_q    <= 1'b0;
      ex_rs_data_q  <= '0;
      ex_rt_data_q  <= '0;
      ex_imm_q      <= '0;
      ex_rs_q       <= '0;
      ex_rt_q       <= '0;
      ex_dest_q     <= '0;
      ex_alusrc_q   <= 1'b0;
      ex_alu_ctl_q  <= 3'b000;
      ex_shamt_q    <= '0;
      ex_regwrite_q <= 1'b0;
      ex_memread_q  <= 1'b0;
      ex_memwrite_q <= 1'b0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_rs_data_q  <= ex_rs_data_d;
      ex_rt_data_q  <= ex_rt_data_d;
      ex_imm_q      <= ex_imm_d;
      ex_rs_q       <= ex_rs_d;
      ex_rt_q       <= ex_rt_d;
      ex_dest_q     <= ex_dest_d;
      ex_alusrc_q   <= ex_alusrc_d;
      ex_alu_ctl_q  <= ex_alu_ctl_d;
      ex_shamt_q    <= ex_shamt_d;
      ex_regwrite_q <= ex_regwrite_d;
      ex_memread_q  <= ex_memread_d;
      ex_memwrite_q <= ex_memwrite_d;
    end
  end

  // EX/MEM is the younger producer so it wins; r0 is hardwired and never forwarded
  always_comb begin
    fwd_rs = ex_rs_data_q;
    if (exmem_regwrite_i && exmem_dest_i == ex_rs_q && ex_rs_q != '0)
      fwd_rs = exmem_result_i;
    else if (memwb_regwrite_i && memwb_dest_i == ex_rs_q && ex_rs_q != '0)
      fwd_rs = memwb_result_i;
  end

  always_comb begin
    fwd_rt = ex_rt_data_q;
    if (exmem_regwrite_i && exmem_dest_i == ex_rt_q && ex_rt_q != '0)
      fwd_rt = exmem_result_i;
    else if (memwb_regwrite_i && memwb_dest_i == ex_rt_q && ex_rt_q != '0)
      fwd_rt = memwb_result_i;
  end

  assign alu_a_o          = fwd_rs;
  assign alu_b_o          = ex_alusrc_q ? ex_imm_q : fwd_rt;
  assign ex_store_data_o  = fwd_rt;
  assign alu_shamt_o      = ex_shamt_q;
  assign alu_control_o    = ex_alu_ctl_q;
  assign ex_valid_o       = ex_valid_q;
  assign ex_dest_o        = ex_dest_q;
  assign ex_regwrite_o    = ex_regwrite_q;
  assign ex_memread_o     = ex_memread_q;
  assign ex_memwrite_o    = ex_memwrite_q;
  assign load_use_stall_o = load_use;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: forwarding/immediate vector table plus
// hand-written stall, flush, load-use and asynchronous-reset sequences.
module tb_id_ex_operand_stage;

  typedef struct packed {
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [15:0] imm;
    logic        zext;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic        alusrc;
    logic [2:0]  ctl;
    logic [5:0]  shamt;
    logic        regwrite;
    logic        memwrite;
    logic        exm_we;
    logic [4:0]  exm_d;
    logic [31:0] exm_r;
    logic        wb_we;
    logic [4:0]  wb_d;
    logic [31:0] wb_r;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [31:0] exp_st;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_imm_zext, id_uses_rt, id_alusrc;
  logic [31:0] id_rs_data, id_rt_data;
  logic [15:0] id_imm;
  logic [4:0]  id_rs, id_rt, id_dest;
  logic [2:0]  id_alu_control;
  logic [5:0]  id_shamt;
  logic        id_regwrite, id_memread, id_memwrite;
  logic        stall, flush;
  logic        exmem_regwrite, memwb_regwrite;
  logic [4:0]  exmem_dest, memwb_dest;
  logic [31:0] exmem_result, memwb_result;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [5:0]  alu_shamt;
  logic [2:0]  alu_control;
  logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, load_use_stall;
  logic [4:0]  ex_dest;

  int n_checks = 0;
  int n_pass   = 0;
  vec_t vecs[8];

  always #5 clk = ~clk;

  id_ex_operand_stage dut (
    .clk_i(clk), .reset_i(reset),
    .id_valid_i(id_valid), .id_rs_data_i(id_rs_data), .id_rt_data_i(id_rt_data),
    .id_imm_i(id_imm), .id_imm_zext_i(id_imm_zext), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .id_uses_rt_i(id_uses_rt), .id_dest_i(id_dest), .id_alusrc_i(id_alusrc),
    .id_alu_control_i(id_alu_control), .id_shamt_i(id_shamt),
    .id_regwrite_i(id_regwrite), .id_memread_i(id_memread), .id_memwrite_i(id_memwrite),
    .stall_i(stall), .flush_i(flush),
    .exmem_regwrite_i(exmem_regwrite), .exmem_dest_i(exmem_dest), .exmem_result_i(exmem_result),
    .memwb_regwrite_i(memwb_regwrite), .memwb_dest_i(memwb_dest), .memwb_result_i(memwb_result),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_shamt_o(alu_shamt), .alu_control_o(alu_control),
    .ex_store_data_o(ex_store_data), .ex_valid_o(ex_valid), .ex_dest_o(ex_dest),
    .ex_regwrite_o(ex_regwrite), .ex_memread_o(ex_memread), .ex_memwrite_o(ex_memwrite),
    .load_use_stall_o(load_use_stall)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_fwd();
    exmem_regwrite = 0; exmem_dest = 0; exmem_result = 0;
    memwb_regwrite = 0; memwb_dest = 0; memwb_result = 0;
  endtask

  task automatic clear_id();
    id_valid = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_imm_zext = 0;
    id_rs = 0; id_rt = 0; id_uses_rt = 0; id_dest = 0; id_alusrc = 0;
    id_alu_control = 0; id_shamt = 0; id_regwrite = 0; id_memread = 0; id_memwrite = 0;
  endtask

  initial begin
    // add r3=r1+r2; both stages produce r1, EX/MEM must win
    vecs[0] = '0;
    vecs[0].rs_data = 32'h1; vecs[0].rt_data = 32'h2; vecs[0].rs = 1; vecs[0].rt = 2;
    vecs[0].dest = 3; vecs[0].ctl = 3'b010; vecs[0].shamt = 6'd0; vecs[0].regwrite = 1;
    vecs[0].exm_we = 1; vecs[0].exm_d = 1; vecs[0].exm_r = 32'h10;
    vecs[0].wb_we = 1; vecs[0].wb_d = 1; vecs[0].wb_r = 32'h20;
    vecs[0].exp_a = 32'h10; vecs[0].exp_b = 32'h2; vecs[0].exp_st = 32'h2;
    // sign-extended negative immediate
    vecs[1] = '0;
    vecs[1].rs_data = 32'h7; vecs[1].rt_data = 32'h55; vecs[1].rs = 4; vecs[1].rt = 6;
    vecs[1].imm = 16'h8000; vecs[1].alusrc = 1; vecs[1].dest = 6; vecs[1].ctl = 3'b010;
    vecs[1].shamt = 6'd3; vecs[1].regwrite = 1;
    vecs[1].exp_a = 32'h7; vecs[1].exp_b = 32'hFFFF8000; vecs[1].exp_st = 32'h55;
    // same immediate zero-extended
    vecs[2] = vecs[1];
    vecs[2].zext = 1; vecs[2].ctl = 3'b001; vecs[2].exp_b = 32'h00008000;
    // r0 is never forwarded even with a matching writer
    vecs[3] = '0;
    vecs[3].dest = 8; vecs[3].ctl = 3'b110; vecs[3].shamt = 6'd63; vecs[3].regwrite = 1;
    vecs[3].exm_we = 1; vecs[3].exm_d = 0; vecs[3].exm_r = 32'hDEAD;
    vecs[3].wb_we = 1; vecs[3].wb_d = 0; vecs[3].wb_r = 32'hBEEF;
    vecs[3].exp_a = 32'h0; vecs[3].exp_b = 32'h0; vecs[3].exp_st = 32'h0;
    // MEM/WB only match on rt
    vecs[4] = '0;
    vecs[4].rs_data = 32'h1111; vecs[4].rt_data = 32'h2222; vecs[4].rs = 10; vecs[4].rt = 7;
    vecs[4].dest = 11; vecs[4].ctl = 3'b111; vecs[4].shamt = 6'd5; vecs[4].regwrite = 1;
    vecs[4].exm_we = 1; vecs[4].exm_d = 8; vecs[4].exm_r = 32'h3333;
    vecs[4].wb_we = 1; vecs[4].wb_d = 7; vecs[4].wb_r = 32'hCAFE;
    vecs[4].exp_a = 32'h1111; vecs[4].exp_b = 32'hCAFE; vecs[4].exp_st = 32'hCAFE;
    // both stages match rt, EX/MEM wins
    vecs[5] = '0;
    vecs[5].rs_data = 32'hA; vecs[5].rt_data = 32'hB; vecs[5].rs = 12; vecs[5].rt = 9;
    vecs[5].dest = 13; vecs[5].ctl = 3'b100; vecs[5].shamt = 6'd31; vecs[5].regwrite = 1;
    vecs[5].exm_we = 1; vecs[5].exm_d = 9; vecs[5].exm_r = 32'h111;
    vecs[5].wb_we = 1; vecs[5].wb_d = 9; vecs[5].wb_r = 32'h222;
    vecs[5].exp_a = 32'hA; vecs[5].exp_b = 32'h111; vecs[5].exp_st = 32'h111;
    // EX/MEM matches but does not write, so MEM/WB supplies rs
    vecs[6] = '0;
    vecs[6].rs_data = 32'hC; vecs[6].rt_data = 32'hD; vecs[6].rs = 14; vecs[6].rt = 15;
    vecs[6].dest = 16; vecs[6].ctl = 3'b011; vecs[6].shamt = 6'd1; vecs[6].regwrite = 1;
    vecs[6].exm_we = 0; vecs[6].exm_d = 14; vecs[6].exm_r = 32'h444;
    vecs[6].wb_we = 1; vecs[6].wb_d = 14; vecs[6].wb_r = 32'h555;
    vecs[6].exp_a = 32'h555; vecs[6].exp_b = 32'hD; vecs[6].exp_st = 32'hD;
    // sw: b is the offset, store data is the forwarded rt
    vecs[7] = '0;
    vecs[7].rs_data = 32'h1000; vecs[7].rt_data = 32'h9; vecs[7].rs = 2; vecs[7].rt = 3;
    vecs[7].imm = 16'h0004; vecs[7].alusrc = 1; vecs[7].dest = 0; vecs[7].ctl = 3'b010;
    vecs[7].memwrite = 1;
    vecs[7].exm_we = 1; vecs[7].exm_d = 3; vecs[7].exm_r = 32'hABC;
    vecs[7].exp_a = 32'h1000; vecs[7].exp_b = 32'h4; vecs[7].exp_st = 32'hABC;

    reset = 1; stall = 0; flush = 0;
    clear_id(); clear_fwd();
    #12;
    chk("rst_ex_valid", {31'b0, ex_valid}, 32'h0);
    chk("rst_alu_control", {29'b0, alu_control}, 32'h0);
    chk("rst_alu_shamt", {26'b0, alu_shamt}, 32'h0);
    chk("rst_alu_a", alu_a, 32'h0);
    chk("rst_alu_b", alu_b, 32'h0);
    chk("rst_enables", {29'b0, ex_regwrite, ex_memread, ex_memwrite}, 32'h0);
    chk("rst_lus", {31'b0, load_use_stall}, 32'h0);
    @(negedge clk);
    reset = 0;

    for (int i = 0; i < 8; i++) begin
      clear_fwd();
      id_valid = 1; id_uses_rt = 1; id_memread = 0;
      id_rs_data = vecs[i].rs_data; id_rt_data = vecs[i].rt_data;
      id_imm = vecs[i].imm; id_imm_zext = vecs[i].zext;
      id_rs = vecs[i].rs; id_rt = vecs[i].rt; id_dest = vecs[i].dest;
      id_alusrc = vecs[i].alusrc; id_alu_control = vecs[i].ctl; id_shamt = vecs[i].shamt;
      id_regwrite = vecs[i].regwrite; id_memwrite = vecs[i].memwrite;
      tick();
      exmem_regwrite = vecs[i].exm_we; exmem_dest = vecs[i].exm_d; exmem_result = vecs[i].exm_r;
      memwb_regwrite = vecs[i].wb_we; memwb_dest = vecs[i].wb_d; memwb_result = vecs[i].wb_r;
      #1;
      chk($sformatf("v%0d_alu_a", i), alu_a, vecs[i].exp_a);
      chk($sformatf("v%0d_alu_b", i), alu_b, vecs[i].exp_b);
      chk($sformatf("v%0d_store", i), ex_store_data, vecs[i].exp_st);
      chk($sformatf("v%0d_ctl", i), {29'b0, alu_control}, {29'b0, vecs[i].ctl});
      chk($sformatf("v%0d_shamt", i), {26'b0, alu_shamt}, {26'b0, vecs[i].shamt});
      chk($sformatf("v%0d_dest", i), {27'b0, ex_dest}, {27'b0, vecs[i].dest});
      chk($sformatf("v%0d_valid", i), {31'b0, ex_valid}, 32'h1);
      chk($sformatf("v%0d_wr", i), {30'b0, ex_regwrite, ex_memwrite},
          {30'b0, vecs[i].regwrite, vecs[i].memwrite});
    end

    // stall holds everything; forwarding still tracks the live sources
    clear_fwd(); clear_id();
    id_valid = 1; id_rs = 1; id_rs_data = 32'h100; id_rt = 2; id_rt_data = 32'h200;
    id_uses_rt = 1; id_alu_control = 3'b110; id_shamt = 6'd7; id_dest = 4; id_regwrite = 1;
    tick();
    chk("stl_pre_a", alu_a, 32'h100);
    stall = 1;
    id_rs_data = 32'hBAD; id_rt_data = 32'hBAD; id_alu_control = 3'b001; id_dest = 9;
    id_shamt = 6'd2;
    tick();
    chk("stl_alu_a", alu_a, 32'h100);
    chk("stl_alu_b", alu_b, 32'h200);
    chk("stl_ctl", {29'b0, alu_control}, 32'h6);
    chk("stl_shamt", {26'b0, alu_shamt}, 32'h7);
    chk("stl_dest", {27'b0, ex_dest}, 32'h4);
    chk("stl_valid", {31'b0, ex_valid}, 32'h1);
    exmem_regwrite = 1; exmem_dest = 1; exmem_result = 32'h777;
    #1;
    chk("stl_fwd_a", alu_a, 32'h777);
    flush = 1;
    tick();
    chk("fls_valid", {31'b0, ex_valid}, 32'h0);
    chk("fls_ctl", {29'b0, alu_control}, 32'h2);
    chk("fls_enables", {29'b0, ex_regwrite, ex_memread, ex_memwrite}, 32'h0);
    chk("fls_alu_a", alu_a, 32'h0);
    stall = 0; flush = 0;

    // load-use: lw r5, then consumer of r5
    clear_fwd(); clear_id();
    id_valid = 1; id_rs = 2; id_rs_data = 32'h40; id_alusrc = 1; id_imm = 16'h8;
    id_dest = 5; id_regwrite = 1; id_memread = 1; id_alu_control = 3'b010;
    tick();
    chk("lu_ex_memread", {31'b0, ex_memread}, 32'h1);
    clear_id();
    id_valid = 1; id_rs = 5; id_rs_data = 32'h99; id_rt = 6; id_rt_data = 32'h66;
    id_uses_rt = 1; id_dest = 7; id_regwrite = 1; id_alu_control = 3'b010;
    #1;
    chk("lu_stall", {31'b0, load_use_stall}, 32'h1);
    tick();
    chk("lu_bub_valid", {31'b0, ex_valid}, 32'h0);
    chk("lu_bub_ctl", {29'b0, alu_control}, 32'h2);
    chk("lu_bub_wr", {31'b0, ex_regwrite}, 32'h0);
    chk("lu_stall_drop", {31'b0, load_use_stall}, 32'h0);
    tick();
    memwb_regwrite = 1; memwb_dest = 5; memwb_result = 32'h1234;
    #1;
    chk("lu_use_valid", {31'b0, ex_valid}, 32'h1);
    chk("lu_use_a", alu_a, 32'h1234);
    chk("lu_use_dest", {27'b0, ex_dest}, 32'h7);

    // lw to r0 never stalls
    clear_fwd(); clear_id();
    id_valid = 1; id_dest = 0; id_regwrite = 1; id_memread = 1;
    tick();
    clear_id();
    id_valid = 1; id_rs = 0; id_regwrite = 1; id_dest = 1;
    #1;
    chk("lu_r0", {31'b0, load_use_stall}, 32'h0);
    // lw r6, then consumer whose rt=6 only matters when rt is read
    clear_id();
    id_valid = 1; id_dest = 6; id_regwrite = 1; id_memread = 1;
    tick();
    clear_id();
    id_valid = 1; id_rs = 3; id_rt = 6; id_uses_rt = 0; id_dest = 1; id_regwrite = 1;
    #1;
    chk("lu_rt_unused", {31'b0, load_use_stall}, 32'h0);
    id_uses_rt = 1;
    #1;
    chk("lu_rt_used", {31'b0, load_use_stall}, 32'h1);
    id_valid = 0;
    #1;
    chk("lu_id_invalid", {31'b0, load_use_stall}, 32'h0);
    id_valid = 1;
    #1;
    // asynchronous reset during a load-use hazard
    reset = 1;
    #1;
    chk("mrst_valid", {31'b0, ex_valid}, 32'h0);
    chk("mrst_ctl", {29'b0, alu_control}, 32'h0);
    chk("mrst_lus", {31'b0, load_use_stall}, 32'h0);
    chk("mrst_memread", {31'b0, ex_memread}, 32'h0);
    @(negedge clk);
    reset = 0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
